// File: rtl/bcd_serial_adder.sv
// Digit-serial NDIG-digit BCD adder, LSD first, one digit per clock with registered decimal carry.
// Optional subtract mode (nine's complement of B, carry-in forced to 1) under `BCD_SUB_EN.
module bcd_serial_adder #(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*NDIG-1:0]   a,
    input  logic [4*NDIG-1:0]   b,
    input  logic                cin,
`ifdef BCD_SUB_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [4*NDIG-1:0]   sum,
    output logic                cout,
    output logic                err
);
    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, shadow_q, shadow_d, sum_q, sum_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d, errsh_q, errsh_d;
    logic            cout_q, cout_d, err_q, err_d, done_q, done_d;

    logic            sub_w;
    logic [W-1:0]    b_cap;
    logic            cin_cap, err_cap, last, cy;
    logic [3:0]      ad, bd, dig;
    logic [4:0]      t;

`ifdef BCD_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    assign last = (idx_q == IW'(NDIG - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == RUN);
    end

    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

    // Capture-side transform; err is judged on the original B digits.
    always_comb begin
        b_cap   = '0;
        err_cap = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            b_cap[4*i +: 4] = sub_w ? (4'd9 - b[4*i +: 4]) : b[4*i +: 4];
            err_cap = err_cap | (a[4*i +: 4] > 4'd9) | (b[4*i +: 4] > 4'd9);
        end
        cin_cap = sub_w ? 1'b1 : cin;
    end

    // Single-digit BCD add/correct on digit idx
    always_comb begin
        ad = 4'd0;
        bd = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) begin
                ad = a_q[4*i +: 4];
                bd = b_q[4*i +: 4];
            end
        end
        t = {1'b0, ad} + {1'b0, bd} + {4'd0, carry_q};
        if (t > 5'd9) begin
            dig = t[3:0] + 4'd6;
            cy  = 1'b1;
        end else begin
            dig = t[3:0];
            cy  = 1'b0;
        end
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        errsh_d  = errsh_q;
        shadow_d = shadow_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        err_d    = err_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                a_d      = a;
                b_d      = b_cap;
                carry_d  = cin_cap;
                errsh_d  = err_cap;
                idx_d    = '0;
                shadow_d = '0;
            end
        end else begin
            for (int i = 0; i < NDIG; i++)
                if (idx_q == IW'(i)) shadow_d[4*i +: 4] = dig;
            carry_d = cy;
            idx_d   = idx_q + IW'(1);
            if (last) begin
                idx_d  = '0;
                sum_d  = shadow_d;
                cout_d = cy;
                err_d  = errsh_q;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            errsh_q  <= 1'b0;
            shadow_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            errsh_q  <= errsh_d;
            shadow_q <= shadow_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder (NDIG=4); subtract vectors only when BCD_SUB_EN is defined.
module tb_bcd_serial_adder;
    localparam int ND = 4;

    logic            clk = 1'b0;
    logic            rst, start, cin, busy, done, cout, err;
    logic [4*ND-1:0] a, b, sum;
`ifdef BCD_SUB_EN
    logic            sub;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.NDIG(ND)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef BCD_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is);
        a   = ia;
        b   = ib;
        cin = ic;
`ifdef BCD_SUB_EN
        sub = is;
`else
        if (is) $display("note: sub ignored in add-only build");
`endif
    endtask

    // Pulses start across one edge, then scrambles inputs to prove they were captured.
    task automatic start_op(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is);
        set_ops(ia, ib, ic, is);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_ops(16'h4321, 16'h8765, ~ic, 1'b0);
    endtask

    task automatic wait_done(input string tag, input logic [15:0] es, input logic ec, input logic ee);
        chk({tag, ".busy0"}, busy, 1);
        for (int i = 1; i < ND; i++) begin
            tick();
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".nodone"}, done, 0);
        end
        tick();
        chk({tag, ".done"}, done, 1);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".err"}, err, ee);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        set_ops(16'h0, 16'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.sum", sum, 0);
        chk("rst.cout", cout, 0);
        chk("rst.err", err, 0);
        rst = 1'b0;
        tick();

        start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        wait_done("t1", 16'h6912, 1'b0, 1'b0);
        tick();
        chk("t1.pulse", done, 0);
        chk("t1.hold", sum, 16'h6912);

        start_op(16'h9999, 16'h0001, 1'b0, 1'b0);
        wait_done("t2", 16'h0000, 1'b1, 1'b0);
        tick();
        start_op(16'h0000, 16'h0000, 1'b1, 1'b0);
        wait_done("t3", 16'h0001, 1'b0, 1'b0);
        tick();

        start_op(16'h00A0, 16'h0000, 1'b0, 1'b0);
        wait_done("t4", 16'h0100, 1'b0, 1'b1);
        tick();

        // Second start while busy is dropped; start in the done cycle is taken.
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        tick();
        set_ops(16'h1111, 16'h1111, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5.done", done, 1);
        chk("t5.sum", sum, 16'h6912);
        start_op(16'h1111, 16'h1111, 1'b0, 1'b0);
        wait_done("t6", 16'h2222, 1'b0, 1'b0);
        tick();

        // Reset mid-operation aborts with no done pulse.
        start_op(16'h9999, 16'h9999, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t7.busy", busy, 0);
        chk("t7.done", done, 0);
        chk("t7.sum", sum, 0);
        chk("t7.cout", cout, 0);
        for (int i = 0; i < ND + 1; i++) begin
            tick();
            chk("t7.nodone", done, 0);
        end
        start_op(16'h1234, 16'h5678, 1'b0, 1'b0);
        wait_done("t8", 16'h6912, 1'b0, 1'b0);
        tick();

`ifdef BCD_SUB_EN
        start_op(16'h5000, 16'h1234, 1'b0, 1'b1);
        wait_done("s1", 16'h3766, 1'b1, 1'b0);
        tick();
        start_op(16'h1234, 16'h5000, 1'b0, 1'b1);
        wait_done("s2", 16'h6234, 1'b0, 1'b0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
- Digit-serial multi-digit BCD adder and sequencer built around the single-digit BCD add/correct rule (binary add, then +6 correction above 9).
- Accepts two packed NDIG-digit BCD operands on a start strobe and processes one digit per clock, LSD first, with a registered decimal carry.
- Returns the packed BCD sum, decimal carry-out and an invalid-digit flag with a one-cycle done pulse.
- Sits between operand capture logic (keypad/switch registers) and the display/result path.

Parameters:
- NDIG, 4, number of BCD digits per operand (1..8); operand/sum width is 4*NDIG.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  4*NDIG  operand A, packed BCD, digit i at [4i+3:4i]
- b  input  4*NDIG  operand B, packed BCD
- cin  input  1  decimal carry-in to digit 0
- busy  output  1  high while digits are being processed
- done  output  1  one-cycle pulse when sum/cout/err are updated
- sum  output  4*NDIG  packed BCD result, held until next completion
- cout  output  1  decimal carry out of digit NDIG-1
- err  output  1  1 if any digit of captured a or b was >9

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state=IDLE; busy=0, done=0, sum=0, cout=0, err=0.
  - Internal operand regs, digit index, carry reg and shadow sum are all 0.
- States: IDLE, RUN.
- IDLE, start=1 at edge k:
  - Capture a, b, cin into internal regs; idx=0; carry=cin.
  - err_shadow = OR over all 2*NDIG captured digits of (digit>9).
  - Go to RUN; busy=1 after edge k.
- IDLE, start=0: hold. done returns to 0 after one cycle.
- RUN, each edge processes digit idx:
  - t = a_idx + b_idx + carry, 5-bit, range 0..31.
  - If t>9: digit = (t+6) mod 16, carry=1. Else digit = t[3:0], carry=0.
  - Digit is written to shadow sum slot idx; idx increments.
- Last RUN edge (idx=NDIG-1), which is edge k+NDIG:
  - sum <= completed shadow; cout <= final carry; err <= err_shadow.
  - done=1 for exactly one cycle; busy=0; state IDLE.
- Latency: done and valid outputs are visible NDIG cycles after the start edge. Throughput is one operation per NDIG cycles.
- start while busy=1 is ignored, with no queueing.
- start in the cycle where done=1 (state already IDLE) is accepted normally.
- Inputs a, b, cin may change freely after the start edge; only captured values are used.
- sum, cout and err never change except at a done edge or on reset. Partial results are never visible.
- Invalid digits (>9) are still processed by the same rule, so the result is deterministic; err flags the condition.
- rst mid-operation: immediate return to IDLE with all outputs 0. No done pulse is produced and the aborted operation is lost.
- NDIG=1: RUN lasts exactly one cycle.

Optional Feature:
- Macro BCD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - If sub=1: each B digit is replaced by the 4-bit wrap of (9 - b_i) (nine's complement), and the initial carry is forced to 1 (cin ignored).
  - Result is a - b in ten's complement. cout=1 means no borrow (a>=b); cout=0 means borrow.
  - err is still computed on the original b digits.
- Not defined: port sub is absent and the block is add-only, exactly as described above.

Test Plan:
- NDIG=4, a=16'h1234, b=16'h5678, cin=0, start pulse -> busy high 4 cycles; done at edge k+4; sum=16'h6912, cout=0, err=0.
- a=16'h9999, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; then a=0, b=0, cin=1 -> sum=16'h0001, cout=0.
- a=16'h00A0, b=16'h0000, cin=0 -> err=1, sum=16'h0100, cout=0.
- Start with 1234+5678; pulse start again 2 cycles later with a=b=16'h1111 -> second start ignored, sum=16'h6912. Start asserted during the done cycle with 16'h1111+16'h1111 -> accepted; 4 cycles later sum=16'h2222.
- Start 9999+9999; assert rst at edge k+2 -> busy=0, no done pulse, sum=0, cout=0; a fresh start then completes normally.
- BCD_SUB_EN, sub=1: 5000-1234 -> sum=16'h3766, cout=1. 1234-5000 -> sum=16'h6234, cout=0.
